// File: rtl/sd_pcm_unpacker_if.sv
// Frame stream between the PCM unpacker and the audio playback path.
//   frame_valid : head frame is available (producer -> consumer)
//   frame_ready : consumer accepts the head frame (consumer -> producer)
//   frame_left  : left 16-bit sample of the head frame
//   frame_right : right 16-bit sample of the head frame
// A frame transfers on any clock edge where frame_valid and frame_ready are both high.
interface sd_pcm_unpacker_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_left;
  logic [15:0] frame_right;

  modport master (output frame_valid, output frame_left, output frame_right, input frame_ready);
  modport slave  (input frame_valid, input frame_left, input frame_right, output frame_ready);
endinterface

// File: rtl/sd_pcm_unpacker.sv
// sd_pcm_unpacker: pulls little-endian bytes (L_lo, L_hi, R_lo, R_hi) from the
// SD controller read FIFO and reassembles them into 16-bit stereo frames. The
// frames go into a first-word-fall-through frame FIFO. The block also counts
// bytes within each SD block and flags playback underruns.
//   clk         : system clock, shared with sdc_controller
//   rstn_async  : asynchronous active-low reset
//   enable      : permits starting a new frame fetch (byte 0 only)
//   flush       : synchronous clear of frame FIFO, assembly and byte counter
//   fifo_empty  : SD read FIFO empty (same-cycle)
//   fifo_rd     : SD read FIFO pop (rd_en_i)
//   fifo_data   : SD read FIFO data, valid the cycle after fifo_rd
//   frm         : frame stream (valid/ready, left/right samples)
//   byte_count  : bytes captured in the current SD block
//   block_done  : one-cycle pulse after the last byte of a block is captured
//   underrun    : one-cycle pulse per starved consumer cycle
module sd_pcm_unpacker #(
  parameter int DEPTH       = 8,
  parameter int BLOCK_BYTES = 512
) (
  input  logic                           clk,
  input  logic                           rstn_async,
  input  logic                           enable,
  input  logic                           flush,
  input  logic                           fifo_empty,
  output logic                           fifo_rd,
  input  logic [7:0]                     fifo_data,
  sd_pcm_unpacker_if.master              frm,
  output logic [$clog2(BLOCK_BYTES)-1:0] byte_count,
  output logic                           block_done,
  output logic                           underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BLOCK_BYTES);

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } frame_t;

  // Issue side
  logic [1:0]    iidx;      // bytes requested in the current frame
  logic [1:0]    asm_cnt;   // frames started but not yet pushed
  logic          rd_d;      // a byte lands on fifo_data this cycle
  logic [AW+1:0] pending;
  logic          room;
  logic          start;

  // Capture side
  logic [1:0] cidx;
  logic [7:0] l_lo, l_hi, r_lo;
  logic       capture;
  logic       push;
  frame_t     push_frame;

  // Frame FIFO
  frame_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   occ;
  logic          pop;
  logic          primed;

  // Frames already in the FIFO plus frames still being assembled reserve
  // space, so a started frame always has a slot waiting for it.
  assign pending = {1'b0, occ} + (AW+2)'(asm_cnt);
  assign room    = pending < (AW+2)'(DEPTH);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fifo_rd = 1'b0;
    if (!fifo_empty && !flush)
      fifo_rd = (iidx != 2'd0) || (enable && room);
  end

  assign start      = fifo_rd && (iidx == 2'd0);
  assign capture    = rd_d && !flush;
  assign push       = capture && (cidx == 2'd3);
  assign push_frame = '{left: {l_hi, l_lo}, right: {fifo_data, r_lo}};
  assign pop        = frm.frame_valid && frm.frame_ready && !flush;

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      iidx    <= 2'd0;
      asm_cnt <= 2'd0;
      rd_d    <= 1'b0;
    end else if (flush) begin
      // Any byte already in flight is dropped along with its frame.
      iidx    <= 2'd0;
      asm_cnt <= 2'd0;
      rd_d    <= 1'b0;
    end else begin
      iidx    <= iidx + 2'(fifo_rd);
      asm_cnt <= asm_cnt + 2'(start) - 2'(push);
      rd_d    <= fifo_rd;
    end
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      cidx       <= 2'd0;
      l_lo       <= 8'd0;
      l_hi       <= 8'd0;
      r_lo       <= 8'd0;
      byte_count <= '0;
      block_done <= 1'b0;
    end else if (flush) begin
      cidx       <= 2'd0;
      byte_count <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= capture && (byte_count == BW'(BLOCK_BYTES - 1));
      if (capture) begin
        cidx       <= cidx + 2'd1;
        byte_count <= byte_count + BW'(1);  // wraps at the block boundary
        case (cidx)
          2'd0:    l_lo <= fifo_data;
          2'd1:    l_hi <= fifo_data;
          2'd2:    r_lo <= fifo_data;
          default: ;                        // slot 3 goes straight into the FIFO
        endcase
      end
    end
  end

  // NOTE: the frame storage has no reset; an entry is only observable after it has been written, and outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= push_frame;
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      primed   <= 1'b0;
      underrun <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      primed   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (pop)
        primed <= 1'b1;
      underrun <= primed && enable && frm.frame_ready && !frm.frame_valid;
    end
  end

  assign frm.frame_valid = (occ != '0);
  assign frm.frame_left  = frm.frame_valid ? mem[rptr].left  : 16'd0;
  assign frm.frame_right = frm.frame_valid ? mem[rptr].right : 16'd0;

endmodule

// File: tb/tb_sd_pcm_unpacker.sv
// Self-checking bench for sd_pcm_unpacker. A behavioural SD read FIFO feeds
// bytes from a queue; expected frames are queued as bytes are supplied and
// compared as the frame stream hands them over.
module tb_sd_pcm_unpacker;

  logic       clk = 1'b0;
  logic       rstn_async;
  logic       enable;
  logic       flush;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data;
  logic [8:0] byte_count;
  logic       block_done;
  logic       underrun;

  sd_pcm_unpacker_if fr();

  sd_pcm_unpacker #(.DEPTH(8), .BLOCK_BYTES(512)) dut (
    .clk        (clk),
    .rstn_async (rstn_async),
    .enable     (enable),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .frm        (fr.master),
    .byte_count (byte_count),
    .block_done (block_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  logic [7:0]  src_q[$];
  logic [31:0] exp_q[$];
  logic        gap;
  logic        rd_s;
  int          n_chk, n_err;
  int          rd_cnt, bd_cnt, ur_cnt, cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_frame(input logic [7:0] b0, b1, b2, b3, input bit track);
    src_q.push_back(b0);
    src_q.push_back(b1);
    src_q.push_back(b2);
    src_q.push_back(b3);
    if (track) exp_q.push_back({b1, b0, b3, b2});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_rd(input string tag, input int target, input int budget);
    int k = 0;
    while (rd_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, rd_cnt >= target, 1);
  endtask

  // SD read FIFO model: data follows a pop by one cycle.
  always begin
    @(negedge clk);
    rd_s = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_s && src_q.size() != 0) fifo_data = src_q.pop_front();
    fifo_empty = gap || (src_q.size() == 0);
  end

  always @(posedge clk) cyc++;

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (rstn_async) begin
      if (fifo_rd)    rd_cnt++;
      if (underrun)   ur_cnt++;
      if (block_done) begin
        bd_cnt++;
        check("byte_count_at_block_done", byte_count, 0);
      end
      if (fr.frame_valid && fr.frame_ready) begin
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("frame_data", {fr.frame_left, fr.frame_right}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int t0, t1, r0, r1, u0, bd0, k;
    rstn_async     = 1'b0;
    enable         = 1'b0;
    flush          = 1'b0;
    gap            = 1'b0;
    fifo_empty     = 1'b1;
    fifo_data      = 8'd0;
    fr.frame_ready = 1'b0;

    // Reset state
    tick(3);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_valid", fr.frame_valid, 0);
    check("rst_left", fr.frame_left, 0);
    check("rst_right", fr.frame_right, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_block_done", block_done, 0);
    check("rst_underrun", underrun, 0);
    rstn_async = 1'b1;
    enable     = 1'b1;
    tick(2);

    // Basic frame and first-frame latency
    push_frame(8'h34, 8'h12, 8'h78, 8'h56, 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!fifo_rd && k < 50);
    t0 = cyc;
    k = 0;
    do begin @(negedge clk); k++; end while (!fr.frame_valid && k < 50);
    t1 = cyc;
    check("basic_latency", t1 - t0, 5);
    check("basic_left", fr.frame_left, 16'h1234);
    check("basic_right", fr.frame_right, 16'h5678);
    tick(1);
    fr.frame_ready = 1'b1;
    wait_drain("basic_drain", 20);
    fr.frame_ready = 1'b0;
    tick(2);

    // Back-pressure: only DEPTH frames worth of bytes may be fetched
    r0 = rd_cnt;
    for (int i = 0; i < 12; i++)
      push_frame(8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 1);
    tick(60);
    check("bp_rd_count", rd_cnt - r0, 32);
    check("bp_valid", fr.frame_valid, 1);
    tick(20);
    check("bp_rd_hold", rd_cnt - r0, 32);
    fr.frame_ready = 1'b1;
    wait_drain("bp_drain", 200);
    check("bp_rd_resumed", rd_cnt - r0, 48);
    tick(3);

    // Empty gap mid-frame
    r0 = rd_cnt;
    src_q.push_back(8'hAA);
    src_q.push_back(8'hBB);
    wait_rd("gap_first_two", r0 + 2, 20);
    gap = 1'b1;
    src_q.push_back(8'hCC);
    src_q.push_back(8'hDD);
    exp_q.push_back(32'hBBAA_DDCC);
    r1 = rd_cnt;
    tick(10);
    check("gap_no_rd", rd_cnt - r1, 0);
    gap = 1'b0;
    wait_drain("gap_drain", 30);
    check("gap_rd_total", rd_cnt - r0, 4);
    tick(3);

    // Underrun: primed, enabled, ready, nothing to give
    u0 = ur_cnt;
    tick(10);
    check("underrun_every_cycle", ur_cnt - u0, 10);

    // Dropping enable mid-frame finishes the frame only
    r0 = rd_cnt;
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 1);
    push_frame(8'h05, 8'h06, 8'h07, 8'h08, 0);
    wait_rd("en_first_byte", r0 + 1, 20);
    enable = 1'b0;
    tick(20);
    check("en_rd_count", rd_cnt - r0, 4);
    check("en_frame_done", exp_q.size(), 0);
    u0 = ur_cnt;
    tick(10);
    check("en_no_underrun", ur_cnt - u0, 0);
    src_q.delete();
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    enable = 1'b1;
    tick(2);

    // Flush after two bytes
    r0 = rd_cnt;
    src_q.push_back(8'hEE);
    src_q.push_back(8'hEF);
    wait_rd("flush_two_bytes", r0 + 2, 20);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_byte_count", byte_count, 0);
    push_frame(8'h11, 8'h22, 8'h33, 8'h44, 1);
    wait_drain("flush_drain", 30);
    check("flush_next_count", byte_count, 4);

    // Block boundary over 1024 bytes
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    bd0 = bd_cnt;
    for (int i = 0; i < 256; i++)
      push_frame(8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 1);
    wait_drain("block_drain", 3000);
    tick(3);
    check("block_done_pulses", bd_cnt - bd0, 2);
    check("block_byte_count", byte_count, 0);

    // Reset after three bytes
    r0 = rd_cnt;
    src_q.push_back(8'h9A);
    src_q.push_back(8'h9B);
    src_q.push_back(8'h9C);
    wait_rd("rst_three_bytes", r0 + 3, 20);
    tick(2);
    rstn_async = 1'b0;
    #1;
    check("mid_rst_fifo_rd", fifo_rd, 0);
    check("mid_rst_valid", fr.frame_valid, 0);
    check("mid_rst_left", fr.frame_left, 0);
    check("mid_rst_right", fr.frame_right, 0);
    check("mid_rst_byte_count", byte_count, 0);
    check("mid_rst_block_done", block_done, 0);
    check("mid_rst_underrun", underrun, 0);
    tick(2);
    rstn_async = 1'b1;
    tick(1);
    push_frame(8'h55, 8'h66, 8'h77, 8'h88, 1);
    wait_drain("rst_drain", 30);
    check("rst_next_count", byte_count, 4);

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
